serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 4 and give the operand width in bits; legal range is 2..32.
REQ-003 Port clk SHALL be a 1-bit input that acts as the sole clock, rising-edge active.
REQ-004 Port rst SHALL be a 1-bit input that provides the synchronous, active-high reset.
REQ-005 Port in_valid SHALL be a 1-bit input that presents an operand set.
REQ-006 Port in_ready SHALL be a 1-bit output that shows the block can accept operands.
REQ-007 Port a SHALL be a WIDTH-bit input carrying the minuend.
REQ-008 Port b SHALL be a WIDTH-bit input carrying the subtrahend.
REQ-009 Port bin SHALL be a 1-bit input carrying the borrow-in.
REQ-010 Port out_valid SHALL be a 1-bit output that flags a valid result.
REQ-011 Port out_ready SHALL be a 1-bit input through which the consumer accepts the result.
REQ-012 Port diff SHALL be a WIDTH-bit output carrying a - b - bin modulo 2^WIDTH.
REQ-013 Port bout SHALL be a 1-bit output carrying the borrow-out, 1 when a < b + bin unsigned.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 On an edge with in_valid=1 and in_ready=1, the block SHALL latch a, b and bin, clear the bit counter and enter RUN.
REQ-017 In RUN, each cycle SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-018 Each d bit SHALL shift into the result register from the MSB end, so that after WIDTH bits bit 0 sits at position 0.
REQ-019 After exactly WIDTH RUN cycles, the block SHALL enter DONE; out_valid SHALL rise WIDTH+1 edges after the accepting edge.
REQ-020 In DONE, out_valid SHALL be 1 and diff/bout SHALL remain stable until out_ready=1.
REQ-021 On an edge with out_valid=1 and out_ready=1, the block SHALL return to IDLE and drop out_valid.
REQ-022 The block SHALL NOT accept new operands on the result-handoff edge; minimum throughput is one operation per WIDTH+2 cycles.
REQ-023 Changes on a, b or bin after acceptance SHALL NOT affect the current result.
REQ-024 Asserting out_ready outside DONE SHALL have no effect.

Reset
REQ-025 While rst=1 at an edge, the state SHALL become IDLE, in_ready SHALL be 1, out_valid SHALL be 0, and diff, bout, the borrow register and the counter SHALL be 0.
REQ-026 Reset SHALL take priority over all handshakes; reset in RUN or DONE SHALL abandon the operation with no result emitted.

Configuration
REQ-027 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add a 1-bit output ovf that gives signed overflow, (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), computed from the latched operands.
REQ-028 With SERIAL_SUB_OVF_EN defined, ovf SHALL be 0 at reset and SHALL follow the same valid/stability rules as diff.
REQ-029 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-031 The per-bit d/br_next logic SHALL be a separate combinational sub-module, full_subtractor (ports diff, bout, a, b, bin), instantiated once.

Verification (WIDTH=4)
REQ-032 The bench SHALL check that a=5, b=3, bin=0 gives diff=2, bout=0, with out_valid rising exactly 5 edges after acceptance.
REQ-033 The bench SHALL check that a=3, b=5, bin=0 gives diff=14, bout=1.
REQ-034 The bench SHALL check that a=0, b=0, bin=1 gives diff=15, bout=1; and that a=8, b=1 gives diff=7, with ovf=1 when SERIAL_SUB_OVF_EN is defined.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check that diff/bout stay stable, in_ready stays 0, and a new in_valid is ignored.
REQ-036 The bench SHALL assert rst on the 2nd RUN cycle and check that the next cycle shows IDLE, in_ready=1 and out_valid=0, and that the following operation 9-4 gives diff=5.
REQ-037 The bench SHALL run back-to-back operations with out_ready=1 and in_valid held high, and check acceptances exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per cycle with valid/ready handshakes.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_br_next;

  full_subtractor u_fs (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_br_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = DONE;
          w_last       = 1'b1;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE: begin
        // No re-accept on the handoff edge: IDLE must be seen for a cycle first.
        if (out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_br        <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == DONE);
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        // Each new bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
        r_diff <= {w_d, r_diff[WIDTH-1:1]};
        r_br   <= w_br_next;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_bout <= w_br_next;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // The final RUN bit is the result MSB, so overflow is resolved on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d ^ r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation; latency counts edges from the accepting edge (inclusive) to out_valid.
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tbin, input logic [3:0] ed, input logic eb, input int hold);
    int n;
    int edges;
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; bin = ~tbin;
    edges = 1;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check({tag, "_lat"}, 32'(edges), 32'd5);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'((ta[3] != tb_[3]) && (ed[3] != ta[3])));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 4'd15; b = 4'd0; bin = 1'b0;
      tick();
      check({tag, "_hold_diff"}, 32'(diff), 32'(ed));
      check({tag, "_hold_bout"}, 32'(bout), 32'(eb));
      check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int acc[$];
    int cyc;
    logic rdy_s;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 4'd0; b = 4'd0; bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_inrdy", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op("5m3", 4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 0);
    run_op("3m5", 4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 0);
    run_op("0m0b", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 0);
    run_op("8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 0);
    run_op("stall", 4'd7, 4'd2, 1'b1, 4'd4, 1'b0, 5);

    // Reset during the second RUN cycle abandons the operation.
    a = 4'd10; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_inrdy", 32'(in_ready), 32'd1);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_rst_noresult", 32'(out_valid), 32'd0);
    run_op("9m4", 4'd9, 4'd4, 1'b0, 4'd5, 1'b0, 0);

    // Back-to-back with out_ready and in_valid held high.
    a = 4'd6; b = 4'd2; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40 && acc.size() < 4; i++) begin
      rdy_s = in_ready;
      if (out_valid) check("b2b_diff", 32'(diff), 32'd4);
      tick();
      cyc++;
      if (rdy_s) acc.push_back(cyc);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", 32'(acc.size()), 32'd4);
    for (int k = 1; k < acc.size(); k++) begin
      check("b2b_gap", 32'(acc[k] - acc[k-1]), 32'd6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
